multi_cycle_ctrl: RTL

//   Multi-cycle control FSM directly downstream of the instruction register.
//   - Consumes the latched instruction fields (opcode/funct) and the ALU flags.
//   - Produces every datapath strobe, including IRWre back to the IR and PCWre to the PC.
//   - Sequences each instruction through IF/ID/EXE/MEM/WB states and counts retired instructions.

---
 rtl/multi_cycle_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM sitting behind the instruction register.
// It sequences IF/ID/EXE/MEM/WB, decodes all datapath strobes and counts retired instructions.
module multi_cycle_ctrl #(
   parameter logic [5:0] OP_HALT = 6'b111111,
   parameter int         CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             PCWre,
   output logic             IRWre,
   output logic             InsMemRW,
   output logic             RegWre,
   output logic             ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic             ExtSel,
   output logic             mRD,
   output logic             mWR,
   output logic             DBDataSrc,
   output logic [1:0]       RegDst,
   output logic             WrRegDSrc,
   output logic [1:0]       PCSrc,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_AEXE = 3'b110,
      S_AWB  = 3'b111,
      S_BEXE = 3'b101,
      S_CEXE = 3'b010,
      S_MEM  = 3'b011,
      S_CWB  = 3'b100
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_JR  = 6'b001000;

   state_t st;

   logic is_r, r_alu, is_jr, is_addi, is_ori, is_slti;
   logic is_beq, is_bne, is_lw, is_sw, is_j, is_jal, is_halt;
   logic is_a, is_b, is_c, is_pass;

   function automatic logic [2:0] alu_sel(input logic [5:0] op, input logic [5:0] fn);
      logic [2:0] sel;
      sel = 3'b000;
      if (op == OP_RTYPE) begin
         case (fn)
            F_SUB:   sel = 3'b001;
            F_AND:   sel = 3'b010;
            F_OR:    sel = 3'b011;
            F_SLT:   sel = 3'b100;
            default: sel = 3'b000;
         endcase
      end else if (op == OP_ORI) begin
         sel = 3'b011;
      end else if (op == OP_SLTI) begin
         sel = 3'b100;
      end
      return sel;
   endfunction

   assign is_r    = (opcode == OP_RTYPE);
   assign r_alu   = is_r && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
   assign is_jr   = is_r && (funct == F_JR);
   assign is_addi = (opcode == OP_ADDI);
   assign is_ori  = (opcode == OP_ORI);
   assign is_slti = (opcode == OP_SLTI);
   assign is_beq  = (opcode == OP_BEQ);
   assign is_bne  = (opcode == OP_BNE);
   assign is_lw   = (opcode == OP_LW);
   assign is_sw   = (opcode == OP_SW);
   assign is_j    = (opcode == OP_J);
   assign is_jal  = (opcode == OP_JAL);
   assign is_halt = (opcode == OP_HALT);

   assign is_a    = r_alu | is_addi | is_ori | is_slti;
   assign is_b    = is_beq | is_bne;
   assign is_c    = is_lw | is_sw;
   // Anything that is not an ALU, branch, memory or halt op finishes in ID: j, jal, jr and NOPs.
   assign is_pass = ~(is_a | is_b | is_c | is_halt);

   assign state = st;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         st      <= S_IF;
         retired <= '0;
      end else begin
         case (st)
            S_IF:   st <= S_ID;
            S_ID: begin
               if (is_a)         st <= S_AEXE;
               else if (is_b)    st <= S_BEXE;
               else if (is_c)    st <= S_CEXE;
               else if (is_halt) st <= S_ID;
               else              st <= S_IF;
            end
            S_AEXE: st <= S_AWB;
            S_AWB:  st <= S_IF;
            S_BEXE: st <= S_IF;
            S_CEXE: st <= S_MEM;
            S_MEM:  st <= is_lw ? S_CWB : S_IF;
            S_CWB:  st <= S_IF;
            default: st <= S_IF;
         endcase
         if (PCWre) retired <= retired + CNT_W'(1);
      end
   end

   // Strobes are forced low while Reset is held so nothing writes during an aborted instruction.
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      RegWre    = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      ExtSel    = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 1'b0;
      PCSrc     = 2'b00;
      if (Reset) begin
         case (st)
            S_IF: begin
               InsMemRW = 1'b1;
               IRWre    = 1'b1;
            end
            S_ID: begin
               if (is_pass) begin
                  PCWre = 1'b1;
                  if (is_j || is_jal) PCSrc = 2'b11;
                  else if (is_jr)     PCSrc = 2'b10;
                  if (is_jal) begin
                     RegWre    = 1'b1;
                     RegDst    = 2'b00;
                     WrRegDSrc = 1'b0;
                  end
               end
            end
            S_AEXE: begin
               ALUSrcB = ~is_r;
               ALUOp   = alu_sel(opcode, funct);
               ExtSel  = is_addi | is_slti;
            end
            S_AWB: begin
               RegWre    = 1'b1;
               WrRegDSrc = 1'b1;
               DBDataSrc = 1'b0;
               PCWre     = 1'b1;
               RegDst    = is_r ? 2'b10 : 2'b01;
            end
            S_BEXE: begin
               ALUOp = 3'b001;
               PCWre = 1'b1;
               PCSrc = ((is_beq & zero) | (is_bne & ~zero)) ? 2'b01 : 2'b00;
            end
            S_CEXE: begin
               ALUSrcB = 1'b1;
               ExtSel  = 1'b1;
               ALUOp   = 3'b000;
            end
            S_MEM: begin
               mRD   = is_lw;
               mWR   = is_sw;
               PCWre = is_sw;
            end
            S_CWB: begin
               RegWre    = 1'b1;
               DBDataSrc = 1'b1;
               RegDst    = 2'b01;
               WrRegDSrc = 1'b1;
               PCWre     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
